// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and the in-flight slot entry type for the hazard scoreboard.
package hazard_scoreboard_pkg;

   localparam int unsigned REG_DEPTH  = 4;
   localparam int unsigned WORD_WIDTH = 32;

   typedef struct packed {
      logic                 valid;
      logic [REG_DEPTH-1:0] dst;
      logic                 wb_en;
      logic                 is_load;
   } slot_t;

endpackage

// File: rtl/hazard_slot_cmp.sv
// Single (source, slot) comparator: flags a pending write to the operand's register.
module hazard_slot_cmp #(
   parameter int unsigned REG_DEPTH = hazard_scoreboard_pkg::REG_DEPTH
) (
   input  logic                 valid,
   input  logic                 wb_en,
   input  logic [REG_DEPTH-1:0] dst,
   input  logic                 src_valid,
   input  logic [REG_DEPTH-1:0] src_addr,
   output logic                 match
);

   assign match = valid & wb_en & src_valid & (dst == src_addr);

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard producing stall and forwarding selects.
// Define FORWARDING_EN for forwarding with load-use stalls; otherwise any pending write stalls.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter  int unsigned REG_DEPTH  = hazard_scoreboard_pkg::REG_DEPTH,
   parameter  int unsigned PIPE_DEPTH = 2,
   parameter  int unsigned NUM_SRC    = 2,
   localparam int unsigned FWD_W      = $clog2(PIPE_DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue_valid,
   input  logic                         issue_wb_en,
   input  logic                         issue_mem_read,
   input  logic [REG_DEPTH-1:0]         issue_dst,
   input  logic [NUM_SRC-1:0]           src_valid,
   input  logic [NUM_SRC*REG_DEPTH-1:0] src_addr,
   input  logic                         flush,
   output logic                         stall,
   output logic [NUM_SRC*FWD_W-1:0]     fwd_sel,
   output logic [15:0]                  stall_count
);

   slot_t                 slot_q [PIPE_DEPTH];
   slot_t                 issue_slot;
   logic [PIPE_DEPTH-1:0] hit [NUM_SRC];
   logic                  stall_raw;
   logic                  accept;
   logic [15:0]           count_q;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_slot
         hazard_slot_cmp #(.REG_DEPTH(REG_DEPTH)) u_cmp (
            .valid     (slot_q[k].valid),
            .wb_en     (slot_q[k].wb_en),
            .dst       (slot_q[k].dst),
            .src_valid (src_valid[s]),
            .src_addr  (src_addr[s*REG_DEPTH +: REG_DEPTH]),
            .match     (hit[s][k])
         );
      end
   end

   always_comb begin
      stall_raw = 1'b0;
      fwd_sel   = '0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         // Walk oldest to youngest so the youngest match is the one left standing.
         for (int unsigned k = PIPE_DEPTH; k > 0; k--) begin
            if (hit[s][k-1]) begin
`ifdef FORWARDING_EN
               fwd_sel[s*FWD_W +: FWD_W] = FWD_W'(k);
`else
               stall_raw = 1'b1;
`endif
            end
         end
`ifdef FORWARDING_EN
         if (hit[s][0] && slot_q[0].is_load) begin
            stall_raw = 1'b1;
         end
`endif
      end
      if (!issue_valid || !rst) begin
         stall_raw = 1'b0;
         fwd_sel   = '0;
      end
   end

   assign stall       = stall_raw & ~flush;
   assign accept      = issue_valid & ~stall & ~flush;
   assign stall_count = count_q;

   always_comb begin
      issue_slot = '0;
      if (accept) begin
         issue_slot.valid   = 1'b1;
         issue_slot.dst     = issue_dst;
         issue_slot.wb_en   = issue_wb_en;
         issue_slot.is_load = issue_mem_read;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            slot_q[k] <= '0;
         end
         count_q <= '0;
      end else begin
         slot_q[0] <= issue_slot;
         for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
            slot_q[k] <= slot_q[k-1];
         end
         if (stall && (count_q != '1)) begin
            count_q <= count_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector tables plus a random run
// against an age-ordered history model; follows the FORWARDING_EN define of the build.
module tb_hazard_scoreboard;

`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int unsigned PD = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid, issue_wb_en, issue_mem_read, flush;
   logic [3:0] issue_dst;
   logic [1:0] src_valid;
   logic [7:0] src_addr;
   logic       stall;
   logic [3:0] fwd_sel;
   logic [15:0] stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_scoreboard #(.REG_DEPTH(4), .PIPE_DEPTH(2), .NUM_SRC(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .issue_valid    (issue_valid),
      .issue_wb_en    (issue_wb_en),
      .issue_mem_read (issue_mem_read),
      .issue_dst      (issue_dst),
      .src_valid      (src_valid),
      .src_addr       (src_addr),
      .flush          (flush),
      .stall          (stall),
      .fwd_sel        (fwd_sel),
      .stall_count    (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         iv, wb, ld;
      logic [3:0] dst;
      logic [1:0] sv;
      logic [3:0] a0, a1;
      bit         fl;
      bit         e_stall;
      int         e_f0, e_f1, e_cnt;
   } vec_t;

   typedef struct packed {
      logic       v, wb, ld;
      logic [3:0] dst;
   } ent_t;

   vec_t        tbl[$];
   ent_t        pipe[$];   // index 0 = most recently issued
   logic [15:0] m_cnt;

   function automatic vec_t mk(bit iv, bit wb, bit ld, logic [3:0] dst, logic [1:0] sv,
                               logic [3:0] a0, logic [3:0] a1, bit fl,
                               bit es, int ef0, int ef1, int ecnt);
      vec_t v;
      v.iv = iv; v.wb = wb; v.ld = ld; v.dst = dst; v.sv = sv; v.a0 = a0; v.a1 = a1;
      v.fl = fl; v.e_stall = es; v.e_f0 = ef0; v.e_f1 = ef1; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit iv, input bit wb, input bit ld, input logic [3:0] dst,
                        input logic [1:0] sv, input logic [3:0] a0, input logic [3:0] a1,
                        input bit fl);
      issue_valid    = iv;
      issue_wb_en    = wb;
      issue_mem_read = ld;
      issue_dst      = dst;
      src_valid      = sv;
      src_addr       = {a1, a0};
      flush          = fl;
   endtask

   task automatic model_reset();
      pipe.delete();
      repeat (PD) pipe.push_back('0);
      m_cnt = '0;
   endtask

   // Age (1 = youngest) of the most recent in-flight writer of register a, 0 if none.
   function automatic int youngest(input logic [3:0] a, input logic use_it);
      for (int i = 0; i < pipe.size(); i++)
         if (use_it && pipe[i].v && pipe[i].wb && pipe[i].dst == a) return i + 1;
      return 0;
   endfunction

   function automatic void model_eval(output bit es, output int f0, output int f1);
      int y0, y1;
      y0 = youngest(src_addr[3:0], src_valid[0]);
      y1 = youngest(src_addr[7:4], src_valid[1]);
      es = 1'b0; f0 = 0; f1 = 0;
      if (issue_valid && rst) begin
         if (FWD) begin
            f0 = y0;
            f1 = y1;
            es = pipe[0].ld && (y0 == 1 || y1 == 1);
         end else begin
            es = (y0 != 0) || (y1 != 0);
         end
         if (flush) es = 1'b0;
      end
   endfunction

   function automatic void model_clock(input bit es);
      ent_t e;
      e = '0;
      if (issue_valid && !es && !flush) begin
         e.v = 1'b1; e.wb = issue_wb_en; e.ld = issue_mem_read; e.dst = issue_dst;
      end
      pipe.push_front(e);
      void'(pipe.pop_back());
      if (es && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
   endfunction

   task automatic step(input bit iv, input bit wb, input bit ld, input logic [3:0] dst,
                       input logic [1:0] sv, input logic [3:0] a0, input logic [3:0] a1,
                       input bit fl, input string tag);
      bit es;
      int ef0, ef1;
      @(negedge clk);
      drive(iv, wb, ld, dst, sv, a0, a1, fl);
      #1;
      model_eval(es, ef0, ef1);
      check({tag, " stall"}, stall, es);
      check({tag, " fwd0"}, fwd_sel[1:0], ef0);
      check({tag, " fwd1"}, fwd_sel[3:2], ef1);
      @(posedge clk);
      #1;
      model_clock(es);
      check({tag, " count"}, stall_count, m_cnt);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #2;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      bit es;
      int ef0, ef1;

      rst = 1'b0;
      drive(1, 1, 0, 4'd1, 2'b11, 4'd1, 4'd1, 0);
      model_reset();
      #12;
      check("reset stall", stall, 0);
      check("reset fwd", fwd_sel, 0);
      check("reset count", stall_count, 0);
      @(negedge clk);
      rst = 1'b1;

      if (FWD) begin
         tbl.push_back(mk(1,1,0, 4'd1,  2'b11, 4'd5,  4'd6,  0, 0,0,0, 0));
         tbl.push_back(mk(1,1,0, 4'd2,  2'b11, 4'd1,  4'd7,  0, 0,1,0, 0));
         tbl.push_back(mk(1,1,1, 4'd3,  2'b01, 4'd8,  4'd0,  0, 0,0,0, 0));
         tbl.push_back(mk(1,1,0, 4'd4,  2'b11, 4'd3,  4'd2,  0, 1,1,2, 1));
         tbl.push_back(mk(1,1,0, 4'd4,  2'b11, 4'd3,  4'd2,  0, 0,2,0, 1));
         tbl.push_back(mk(1,1,1, 4'd9,  2'b01, 4'd4,  4'd0,  0, 0,1,0, 1));
         tbl.push_back(mk(1,1,0, 4'd10, 2'b01, 4'd9,  4'd0,  1, 0,1,0, 1));
         tbl.push_back(mk(1,1,0, 4'd11, 2'b11, 4'd9,  4'd10, 0, 0,2,0, 1));
         tbl.push_back(mk(0,1,0, 4'd12, 2'b11, 4'd11, 4'd11, 0, 0,0,0, 1));
         tbl.push_back(mk(1,1,0, 4'd15, 2'b00, 4'd0,  4'd0,  0, 0,0,0, 1));
         tbl.push_back(mk(1,0,0, 4'd0,  2'b10, 4'd0,  4'd15, 0, 0,0,1, 1));
         tbl.push_back(mk(1,1,0, 4'd5,  2'b11, 4'd15, 4'd15, 0, 0,2,2, 1));
      end else begin
         tbl.push_back(mk(1,1,0, 4'd1,  2'b11, 4'd5,  4'd6,  0, 0,0,0, 0));
         tbl.push_back(mk(1,0,0, 4'd0,  2'b00, 4'd0,  4'd0,  0, 0,0,0, 0));
         tbl.push_back(mk(1,1,0, 4'd2,  2'b01, 4'd1,  4'd0,  0, 1,0,0, 1));
         tbl.push_back(mk(1,1,0, 4'd2,  2'b01, 4'd1,  4'd0,  0, 0,0,0, 1));
         tbl.push_back(mk(1,1,1, 4'd3,  2'b01, 4'd8,  4'd0,  0, 0,0,0, 1));
         tbl.push_back(mk(1,1,0, 4'd4,  2'b01, 4'd3,  4'd0,  1, 0,0,0, 1));
         tbl.push_back(mk(1,1,0, 4'd5,  2'b01, 4'd4,  4'd0,  0, 0,0,0, 1));
         tbl.push_back(mk(0,1,0, 4'd6,  2'b01, 4'd5,  4'd0,  0, 0,0,0, 1));
         tbl.push_back(mk(1,1,0, 4'd15, 2'b10, 4'd0,  4'd5,  0, 1,0,0, 2));
         tbl.push_back(mk(1,1,0, 4'd15, 2'b10, 4'd0,  4'd5,  0, 0,0,0, 2));
         tbl.push_back(mk(1,0,0, 4'd0,  2'b01, 4'd15, 4'd0,  0, 1,0,0, 3));
      end

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].iv, tbl[i].wb, tbl[i].ld, tbl[i].dst, tbl[i].sv, tbl[i].a0,
               tbl[i].a1, tbl[i].fl);
         #1;
         check($sformatf("row%0d stall", i), stall, tbl[i].e_stall);
         check($sformatf("row%0d fwd0", i), fwd_sel[1:0], tbl[i].e_f0);
         check($sformatf("row%0d fwd1", i), fwd_sel[3:2], tbl[i].e_f1);
         @(posedge clk);
         #1;
         check($sformatf("row%0d count", i), stall_count, tbl[i].e_cnt);
      end

      // Saturation: start the counter just below the ceiling and provoke repeated stalls.
      do_reset();
      force dut.count_q = 16'hFFFE;
      #1;
      release dut.count_q;
      m_cnt = 16'hFFFE;
      for (int i = 0; i < 6; i++)
         step(1, 1, 1, 4'd3, 2'b01, 4'd3, 4'd0, 0, $sformatf("sat%0d", i));
      check("sat final", stall_count, 16'hFFFF);

      // Asynchronous reset with two live slots.
      step(1, 1, 0, 4'd1, 2'b00, 4'd0, 4'd0, 0, "rmo a");
      step(1, 1, 0, 4'd2, 2'b00, 4'd0, 4'd0, 0, "rmo b");
      @(negedge clk);
      drive(1, 0, 0, 4'd0, 2'b11, 4'd1, 4'd2, 0);
      #1;
      model_eval(es, ef0, ef1);
      check("rmo pre stall", stall, es);
      check("rmo pre fwd0", fwd_sel[1:0], ef0);
      check("rmo pre fwd1", fwd_sel[3:2], ef1);
      #2;
      rst = 1'b0;
      #1;
      check("rmo stall", stall, 0);
      check("rmo fwd", fwd_sel, 0);
      check("rmo count", stall_count, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      step(1, 0, 0, 4'd0, 2'b11, 4'd1, 4'd2, 0, "rmo post");

      for (int i = 0; i < 600; i++) begin
         logic [3:0] d, a0, a1;
         d  = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
         a0 = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
         a1 = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
         step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, d, 2'($urandom_range(0, 3)), a0, a1,
              $urandom_range(0, 7) == 0, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_DEPTH, default 4, meaning register-address width.
REQ-002 SHALL have parameter PIPE_DEPTH, default 2, meaning number of tracked in-flight slots (slot 1 = EXE, slot 2 = MEM, ...).
REQ-003 SHALL have parameter NUM_SRC, default 2, meaning number of source operands checked per issue.
REQ-004 SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port issue_valid, input, 1, which means the ID stage holds an instruction requesting issue.
REQ-007 SHALL have ports issue_wb_en, input, 1, and issue_mem_read, input, 1, which are the writeback enable and load flag of the issuing instruction.
REQ-008 SHALL have port issue_dst, input, REG_DEPTH, the destination register.
REQ-009 SHALL have ports src_valid, input, NUM_SRC, and src_addr, input, NUM_SRC*REG_DEPTH, which carry per-source use flags and addresses.
REQ-010 SHALL have port flush, input, 1, meaning branch taken in EXE: discard the ID instruction.
REQ-011 SHALL have port stall, output, 1, which freezes IF/ID and inserts a bubble.
REQ-012 SHALL have port fwd_sel, output, NUM_SRC*FWD_W, with FWD_W = clog2(PIPE_DEPTH+1); per source, 0 = register file and k = slot k result.
REQ-013 SHALL have port stall_count, output, 16, the saturating count of stall cycles.

Function
REQ-014 SHALL hold PIPE_DEPTH slots, each {valid, dst, wb_en, is_load}, in a registered shift chain.
REQ-015 SHALL, at each clock edge, shift slot[k] to slot[k+1] and retire slot[PIPE_DEPTH].
REQ-016 SHALL load slot[1] with the issuing instruction when accept = issue_valid & ~stall & ~flush, and with an invalid bubble otherwise.
REQ-017 SHALL define a slot k match for source s as valid & wb_en & (dst == src_addr[s]) & src_valid[s].
REQ-018 SHALL compute stall and fwd_sel combinationally from the slot state and current inputs, with zero-cycle latency.
REQ-019 SHALL give the lowest-index (youngest) matching slot priority for each source.
REQ-020 SHALL force stall to 0 whenever flush = 1; flush wins over stall and slot[1] receives a bubble.
REQ-021 SHALL drive stall = 0 and fwd_sel = 0 when issue_valid = 0.
REQ-022 SHALL increment stall_count on each cycle with stall = 1 and saturate at 16'hFFFF without wrap-around.
REQ-023 SHALL compare all slots against the decoded sources, so register R15 receives no special treatment.

Reset
REQ-024 SHALL, while rst = 0 and independent of clk, clear all slot valid bits, drive stall = 0 and fwd_sel = 0, and clear stall_count to 0.
REQ-025 SHALL, when rst is asserted mid-operation, discard all in-flight entries, and SHALL treat the first cycle after release as hazard-free.

Configuration
REQ-026 SHALL, with FORWARDING_EN defined, set fwd_sel to the youngest matching slot index and assert stall only on a match in slot 1 with is_load = 1 (load-use).
REQ-027 SHALL, without FORWARDING_EN, tie fwd_sel to 0 and assert stall on any match in any slot.

Structure
REQ-028 SHALL take REG_DEPTH, WORD_WIDTH and the slot-entry typedef from the shared constants package.
REQ-029 SHALL compute FWD_W locally.
REQ-030 SHALL instantiate one sub-module, hazard_slot_cmp, per (source, slot) pair, each producing a match bit.

Verification
REQ-031 SHALL be checked for back-to-back dependency with forwarding: ADD R1 then SUB R2,R1 -> stall = 0 and fwd_sel[src0] = 1.
REQ-032 SHALL be checked for load-use with forwarding: LDR R3 then ADD R4,R3 -> stall = 1 for one cycle, then fwd_sel[src0] = 2, and stall_count = 1.
REQ-033 SHALL be checked without FORWARDING_EN: ADD R1, then a NOP, then use of R1 -> stall = 1 for exactly one cycle (R1 in slot 2), then fwd_sel = 0.
REQ-034 SHALL be checked for flush during hazard: load-use condition together with flush = 1 -> stall = 0 and slot[1] invalid on the next cycle.
REQ-035 SHALL be checked for saturation: preload stall_count at 16'hFFFE, then three stall cycles -> stall_count = 16'hFFFF.
REQ-036 SHALL be checked for reset mid-operation: two valid slots, then rst = 0 asynchronously -> stall = 0 and fwd_sel = 0 immediately, with all slots invalid.
